// File: rtl/lat_mon_pkg.sv
// lat_mon_pkg: violation codes, channel states and shared widths for lat_window_monitor.
package lat_mon_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [CODE_W-1:0] {
        NONE     = 3'd0,
        EARLY    = 3'd1,
        LATE     = 3'd2,
        SPURIOUS = 3'd3,
        OVERLAP  = 3'd4,
        MISMATCH = 3'd5
    } viol_code_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

endpackage

// File: rtl/lat_window_chan.sv
// lat_window_chan: one trigger-to-response latency window checker.
// LAT_MON_DATA_CHECK_EN adds payload capture and MISMATCH reporting.
module lat_window_chan
    import lat_mon_pkg::*;
#(
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = 4,
    parameter int DATA_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_trig,
    input  logic              i_resp,
    input  logic [DATA_W-1:0] i_trig_data,
    input  logic [DATA_W-1:0] i_resp_data,
    output logic              o_pass_now,
    output logic              o_viol_now,
    output logic              o_viol_pulse,
    output logic [CODE_W-1:0] o_last_code,
    output logic [LAT_W-1:0]  o_last_lat
);

    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

    chan_state_e       r_state, w_state_nx;
    logic [LAT_W-1:0]  r_lat, w_lat_nx;
    viol_code_e        w_code;
    logic              w_pass, w_match;
    logic              r_viol_pulse;
    logic [CODE_W-1:0] r_last_code;
    logic [LAT_W-1:0]  r_last_lat;

`ifdef LAT_MON_DATA_CHECK_EN
    logic [DATA_W-1:0] r_cap;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cap <= '0;
        else if (i_en && i_trig)
            r_cap <= i_trig_data;
    end

    assign w_match = (r_cap == i_resp_data);
`else
    logic w_unused_data;

    assign w_unused_data = ^{i_trig_data, i_resp_data};
    assign w_match       = 1'b1;
`endif

    // A trig always opens a fresh window after whatever this cycle resolved.
    always_comb begin
        w_state_nx = r_state;
        w_lat_nx   = r_lat;
        w_code     = NONE;
        w_pass     = 1'b0;
        if (!i_en) begin
            w_state_nx = IDLE;
            w_lat_nx   = '0;
        end else if (r_state == IDLE) begin
            if (i_resp)
                w_code = SPURIOUS;
        end else if (i_resp) begin
            w_state_nx = IDLE;
            if (r_lat < MIN_L)
                w_code = EARLY;
            else if (!w_match)
                w_code = MISMATCH;
            else
                w_pass = 1'b1;
        end else if (r_lat == MAX_L) begin
            w_state_nx = IDLE;
            w_code     = LATE;
        end else begin
            w_lat_nx = r_lat + 1'b1;
            if (i_trig)
                w_code = OVERLAP;
        end
        if (i_en && i_trig) begin
            w_state_nx = WAIT;
            w_lat_nx   = LAT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_lat        <= '0;
            r_viol_pulse <= 1'b0;
            r_last_code  <= '0;
            r_last_lat   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_lat        <= w_lat_nx;
            r_viol_pulse <= o_viol_now && !i_clr;
            if (i_clr)
                r_last_code <= '0;
            else if (o_viol_now)
                r_last_code <= w_code;
            if (w_pass)
                r_last_lat <= r_lat;
        end
    end

    assign o_pass_now   = w_pass;
    assign o_viol_now   = (w_code != NONE);
    assign o_viol_pulse = r_viol_pulse;
    assign o_last_code  = r_last_code;
    assign o_last_lat   = r_last_lat;

endmodule

// File: rtl/lat_window_monitor.sv
// lat_window_monitor: NUM_CH latency-window checkers with sticky flags and saturating counters.
// LAT_MON_DATA_CHECK_EN enables per-channel payload comparison (MISMATCH).
module lat_window_monitor
    import lat_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int DATA_W  = 8
) (
    input  logic                     REF_CLK,
    input  logic                     RST,
    input  logic                     mon_en,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        trig,
    input  logic [NUM_CH-1:0]        resp,
    input  logic [NUM_CH*DATA_W-1:0] trig_data,
    input  logic [NUM_CH*DATA_W-1:0] resp_data,
    output logic [NUM_CH-1:0]        viol_pulse,
    output logic [NUM_CH-1:0]        err_sticky,
    output logic [NUM_CH*CODE_W-1:0] last_code,
    output logic [NUM_CH*LAT_W-1:0]  last_lat,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         viol_cnt
);

    localparam logic [CNT_W+4:0] CNT_MAX = {5'd0, {CNT_W{1'b1}}};

    logic [NUM_CH-1:0] w_pass_now, w_viol_now;
    logic [NUM_CH-1:0] r_err_sticky;
    logic [CNT_W-1:0]  r_pass_cnt, r_viol_cnt;
    logic [4:0]        w_pass_n, w_viol_n;
    logic [CNT_W+4:0]  w_pass_sum, w_viol_sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lat_window_chan #(
            .MIN_LAT(MIN_LAT),
            .MAX_LAT(MAX_LAT),
            .LAT_W  (LAT_W),
            .DATA_W (DATA_W)
        ) u_chan (
            .i_clk       (REF_CLK),
            .i_rst       (RST),
            .i_en        (mon_en),
            .i_clr       (clr),
            .i_trig      (trig[i]),
            .i_resp      (resp[i]),
            .i_trig_data (trig_data[i*DATA_W +: DATA_W]),
            .i_resp_data (resp_data[i*DATA_W +: DATA_W]),
            .o_pass_now  (w_pass_now[i]),
            .o_viol_now  (w_viol_now[i]),
            .o_viol_pulse(viol_pulse[i]),
            .o_last_code (last_code[i*CODE_W +: CODE_W]),
            .o_last_lat  (last_lat[i*LAT_W +: LAT_W])
        );
    end

    always_comb begin
        w_pass_n = '0;
        w_viol_n = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_pass_n = w_pass_n + 5'(w_pass_now[k]);
            w_viol_n = w_viol_n + 5'(w_viol_now[k]);
        end
    end

    // Sums are wide enough to hold the max count plus 16 strobes without wrapping.
    assign w_pass_sum = (CNT_W+5)'(r_pass_cnt) + (CNT_W+5)'(w_pass_n);
    assign w_viol_sum = (CNT_W+5)'(r_viol_cnt) + (CNT_W+5)'(w_viol_n);

    always_ff @(posedge REF_CLK) begin
        if (RST || clr) begin
            r_err_sticky <= '0;
            r_pass_cnt   <= '0;
            r_viol_cnt   <= '0;
        end else begin
            r_err_sticky <= r_err_sticky | w_viol_now;
            r_pass_cnt   <= (w_pass_sum > CNT_MAX) ? '1 : w_pass_sum[CNT_W-1:0];
            r_viol_cnt   <= (w_viol_sum > CNT_MAX) ? '1 : w_viol_sum[CNT_W-1:0];
        end
    end

    assign err_sticky = r_err_sticky;
    assign pass_cnt   = r_pass_cnt;
    assign viol_cnt   = r_viol_cnt;

endmodule

// File: tb/tb_lat_window_monitor.sv
// tb_lat_window_monitor: directed vectors with hand-computed expectations for lat_window_monitor.
module tb_lat_window_monitor;

    logic        REF_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mon_en = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  trig = '0;
    logic [3:0]  resp = '0;
    logic [31:0] trig_data = '0;
    logic [31:0] resp_data = '0;
    logic [3:0]  viol_pulse, err_sticky;
    logic [11:0] last_code;
    logic [15:0] last_lat;
    logic [7:0]  pass_cnt, viol_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 REF_CLK = ~REF_CLK;

    lat_window_monitor dut (
        .REF_CLK   (REF_CLK),
        .RST       (RST),
        .mon_en    (mon_en),
        .clr       (clr),
        .trig      (trig),
        .resp      (resp),
        .trig_data (trig_data),
        .resp_data (resp_data),
        .viol_pulse(viol_pulse),
        .err_sticky(err_sticky),
        .last_code (last_code),
        .last_lat  (last_lat),
        .pass_cnt  (pass_cnt),
        .viol_cnt  (viol_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge REF_CLK);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] t, input logic [3:0] r);
        trig = t;
        resp = r;
        tick();
        trig = '0;
        resp = '0;
    endtask

    initial begin
        tick(3);
        check("rst_viol_pulse", 32'(viol_pulse), 0);
        check("rst_sticky", 32'(err_sticky), 0);
        check("rst_code", 32'(last_code), 0);
        check("rst_lat", 32'(last_lat), 0);
        check("rst_pass", 32'(pass_cnt), 0);
        check("rst_viol", 32'(viol_cnt), 0);
        RST = 1'b0;
        mon_en = 1'b1;
        tick();

        // ch0 pass at lat 3
        pulse(4'h1, 4'h0);
        tick(2);
        pulse(4'h0, 4'h1);
        check("a_pass_cnt", 32'(pass_cnt), 1);
        check("a_last_lat0", 32'(last_lat[3:0]), 3);
        check("a_no_viol", 32'(viol_pulse), 0);

        // ch1 EARLY at lat 1
        pulse(4'h2, 4'h0);
        pulse(4'h0, 4'h2);
        check("b_viol_pulse", 32'(viol_pulse), 32'h2);
        check("b_code1", 32'(last_code[5:3]), 1);
        check("b_sticky", 32'(err_sticky), 32'h2);
        check("b_viol_cnt", 32'(viol_cnt), 1);
        tick();
        check("b_pulse_one_cycle", 32'(viol_pulse), 0);
        check("b_sticky_hold", 32'(err_sticky), 32'h2);

        // ch2 LATE after lat 4
        pulse(4'h4, 4'h0);
        tick(3);
        check("c_not_yet", 32'(viol_pulse), 0);
        tick();
        check("c_viol_pulse", 32'(viol_pulse), 32'h4);
        check("c_code2", 32'(last_code[8:6]), 2);
        check("c_viol_cnt", 32'(viol_cnt), 2);
        check("c_sticky", 32'(err_sticky), 32'h6);
        tick(5);
        check("c_idle_after", 32'(viol_cnt), 2);

        // ch3 OVERLAP then pass at lat 3
        pulse(4'h8, 4'h0);
        tick();
        pulse(4'h8, 4'h0);
        check("d_overlap_pulse", 32'(viol_pulse), 32'h8);
        check("d_code3", 32'(last_code[11:9]), 4);
        check("d_viol_cnt", 32'(viol_cnt), 3);
        tick(2);
        pulse(4'h0, 4'h8);
        check("d_pass_cnt", 32'(pass_cnt), 2);
        check("d_last_lat3", 32'(last_lat[15:12]), 3);
        check("d_no_viol", 32'(viol_pulse), 0);

        // ch0 resolving resp with a new trig, then second window
        pulse(4'h1, 4'h0);
        tick();
        pulse(4'h1, 4'h1);
        check("e_pass_cnt", 32'(pass_cnt), 3);
        check("e_last_lat0", 32'(last_lat[3:0]), 2);
        check("e_no_viol", 32'(viol_pulse), 0);
        tick();
        pulse(4'h0, 4'h1);
        check("e_pass2", 32'(pass_cnt), 4);

        // ch1 trig+resp while idle: spurious, window still opens
        pulse(4'h2, 4'h2);
        check("f_viol_cnt", 32'(viol_cnt), 4);
        check("f_code1", 32'(last_code[5:3]), 3);
        tick(2);
        pulse(4'h0, 4'h2);
        check("f_pass_cnt", 32'(pass_cnt), 5);
        check("f_last_lat1", 32'(last_lat[7:4]), 3);

        // mon_en low discards window and suppresses strays
        pulse(4'h4, 4'h0);
        mon_en = 1'b0;
        tick(6);
        check("g_no_late", 32'(viol_cnt), 4);
        pulse(4'h0, 4'h4);
        check("g_no_spurious", 32'(viol_cnt), 4);
        check("g_pass_hold", 32'(pass_cnt), 5);
        mon_en = 1'b1;
        tick();

        // all channels stray in one cycle
        pulse(4'h0, 4'hF);
        check("h_viol_cnt", 32'(viol_cnt), 8);
        check("h_pulse", 32'(viol_pulse), 32'hF);
        check("h_codes", 32'(last_code), 32'h6DB);
        check("h_sticky", 32'(err_sticky), 32'hF);

        // clr coincident with a strobe drops it
        clr = 1'b1;
        pulse(4'h0, 4'h1);
        clr = 1'b0;
        check("i_viol_cnt", 32'(viol_cnt), 0);
        check("i_pass_cnt", 32'(pass_cnt), 0);
        check("i_sticky", 32'(err_sticky), 0);
        check("i_code", 32'(last_code), 0);
        check("i_pulse", 32'(viol_pulse), 0);
        check("i_last_lat", 32'(last_lat), 32'h3032);

        // saturation
        for (int n = 0; n < 75; n++)
            pulse(4'h0, 4'hF);
        check("j_sat", 32'(viol_cnt), 255);
        pulse(4'h0, 4'hF);
        check("j_sat_hold", 32'(viol_cnt), 255);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("j_clr", 32'(viol_cnt), 0);

        // payload check at lat 2
        trig_data[7:0] = 8'hA5;
        resp_data[7:0] = 8'h5A;
        pulse(4'h1, 4'h0);
        tick();
        pulse(4'h0, 4'h1);
`ifdef LAT_MON_DATA_CHECK_EN
        check("k_mm_viol", 32'(viol_cnt), 1);
        check("k_mm_pass", 32'(pass_cnt), 0);
        check("k_mm_code", 32'(last_code[2:0]), 5);
`else
        check("k_ign_viol", 32'(viol_cnt), 0);
        check("k_ign_pass", 32'(pass_cnt), 1);
`endif
        resp_data[7:0] = 8'hA5;
        pulse(4'h1, 4'h0);
        tick();
        pulse(4'h0, 4'h1);
`ifdef LAT_MON_DATA_CHECK_EN
        check("k_match_pass", 32'(pass_cnt), 1);
`else
        check("k_match_pass", 32'(pass_cnt), 2);
`endif
        check("k_match_lat", 32'(last_lat[3:0]), 2);

        // reset mid-window reports nothing
        pulse(4'h1, 4'h0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick(6);
        check("l_viol_cnt", 32'(viol_cnt), 0);
        check("l_pass_cnt", 32'(pass_cnt), 0);
        check("l_pulse", 32'(viol_pulse), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lat_window_monitor.md
Name: lat_window_monitor

Overview:
- Synthesizable, parametrised latency-window checker for NUM_CH independent request/response channels, all in the REF_CLK domain.
- Each channel checks that a trigger pulse is followed by a response pulse between MIN_LAT and MAX_LAT cycles later, for example data_valid to enable_pulse, or gate_en to en.
- Violations are classified, flagged per channel and counted globally.
- Used as an on-chip debug/safety monitor alongside the system controller. Unlike simulation-only assertions, it can be read from silicon.

Parameters:
- NUM_CH, 4: number of monitored channels (1..16).
- MIN_LAT, 2: minimum legal trigger-to-response latency in cycles (≥1).
- MAX_LAT, 4: maximum legal latency in cycles (≥MIN_LAT, <2^LAT_W).
- LAT_W, 4: width of each per-channel latency counter.
- CNT_W, 8: width of the global pass and violation counters.
- DATA_W, 8: payload width used by the optional data check.

Ports:
- REF_CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- mon_en  in  1  global enable; low holds every channel in IDLE and suppresses all events.
- clr  in  1  synchronous clear of counters and sticky flags.
- trig  in  NUM_CH  per-channel trigger pulse.
- resp  in  NUM_CH  per-channel response pulse.
- trig_data  in  NUM_CH*DATA_W  payload captured on trigger; channel i is slice [i*DATA_W +: DATA_W].
- resp_data  in  NUM_CH*DATA_W  payload sampled on response.
- viol_pulse  out  NUM_CH  one-cycle violation strobe per channel.
- err_sticky  out  NUM_CH  set on violation; cleared by RST or clr.
- last_code  out  NUM_CH*3  last violation code per channel.
- last_lat  out  NUM_CH*LAT_W  latency of the last passing response.
- pass_cnt  out  CNT_W  saturating count of passing responses.
- viol_cnt  out  CNT_W  saturating count of violations.

Behaviour:
- Reset: every output is 0 and every channel FSM is IDLE. Reset wins over clr and mon_en.
- Per-channel FSM has two states, IDLE and WAIT, plus a counter lat of LAT_W bits.
- IDLE + trig: go to WAIT and load lat=1 in the next cycle.
  - lat therefore equals the number of cycles since the trigger edge.
  - A resp in the same cycle as the trig is treated as a stray response (SPURIOUS).
- IDLE + resp without trig: SPURIOUS violation; stay IDLE.
- WAIT, each cycle:
  - resp with lat<MIN_LAT: EARLY violation; go to IDLE.
  - resp with MIN_LAT≤lat≤MAX_LAT: pass; last_lat<=lat; go to IDLE.
  - No resp and lat==MAX_LAT: LATE violation; go to IDLE.
  - Otherwise lat<=lat+1. The counter never wraps, because MAX_LAT<2^LAT_W.
- WAIT + trig in the same cycle as a resolving resp: the resolution is recorded first, then a new window starts (WAIT, lat=1).
- WAIT + trig with no resolution: OVERLAP violation; the window restarts (lat=1).
- Violation codes, 3 bits: NONE=0, EARLY=1, LATE=2, SPURIOUS=3, OVERLAP=4, MISMATCH=5.
- Violation timing: viol_pulse, err_sticky and last_code update registered, in the cycle after the causing edge (1-cycle latency). Passes update last_lat and pass_cnt with the same latency.
- Global counters:
  - Each adds the popcount of that cycle's per-channel pass/violation strobes.
  - Each saturates at 2^CNT_W-1 and never wraps.
- clr: zeroes pass_cnt, viol_cnt, err_sticky and last_code. FSMs, last_lat and in-flight windows are unaffected.
  - A strobe coincident with clr is dropped; clr has priority.
- mon_en low: FSMs are forced to IDLE immediately and any pending window is discarded silently. Counters and flags hold.
- Reset mid-window: the window is discarded with no violation reported.

Optional Feature:
- Macro: LAT_MON_DATA_CHECK_EN.
- Defined:
  - trig_data is captured per channel on the trig that opens a window.
  - On an in-window resp, resp_data is compared with the captured payload.
  - A mismatch is reported as MISMATCH instead of pass: it counts in viol_cnt, not pass_cnt.
- Not defined: no capture registers are built; the data ports remain but are ignored, and MISMATCH never occurs.

Decomposition:
- Package lat_mon_pkg holds:
  - viol_code_e, a 3-bit enum with the codes above;
  - chan_state_e, {IDLE, WAIT};
  - localparam CODE_W=3.
- Sub-module lat_window_chan contains one channel's FSM, lat counter, last_code, last_lat and optional data capture.
- The top generates NUM_CH instances and performs the popcount/saturating accumulation, the sticky flags and clr handling.

Test Plan:
- Default params, ch0 trig at cycle 10 and resp at cycle 13 (lat 3) -> pass_cnt=1, last_lat[0]=3, no viol_pulse.
- ch1 trig at cycle 10, resp at cycle 11 (lat 1) -> viol_pulse[1] at cycle 12, last_code=EARLY, err_sticky[1]=1, viol_cnt=1.
- ch2 trig at cycle 10, no resp -> LATE at lat 4, viol_pulse[2] at cycle 15, FSM back to IDLE.
- ch3 trig at 10, re-trig at 12, resp at 15 -> OVERLAP at 12, then pass with last_lat=3; viol_cnt=1, pass_cnt=1.
- All 4 channels send stray resp in one cycle -> viol_cnt +4 in one step. Then 300 violations with CNT_W=8 -> viol_cnt=255, held. Then clr -> 0.
- With LAT_MON_DATA_CHECK_EN: trig_data=0xA5, resp at lat 2 with resp_data=0x5A -> MISMATCH, pass_cnt unchanged. Repeat with resp_data=0xA5 -> pass.
